req_grant_sched: RTL and testbench

- Round-robin scheduler that shares one resource among N_REQ requesters using a req/grant handshake.
- Grant has a fixed two-edge latency from the request and a bounded hold window of MIN_HOLD..MAX_HOLD consecutive cycles. The defaults give the req |=> ##1 grant[*3:5] contract.
- Sits between requester agents and the shared resource. Drives a one-hot grant vector and the index of the current owner.

---
 rtl/req_grant_sched_pkg.sv | 22 ++
 rtl/req_grant_sched_rr_pick.sv | 31 +++
 rtl/req_grant_sched.sv | 109 ++++++++++
 tb/tb_req_grant_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_grant_sched_pkg.sv
// req_grant_sched shared types and constants.
// FSM states, default hold window, counter width helper.
package req_grant_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    GRANT
  } state_e;

  localparam int DEF_MIN_HOLD = 3;
  localparam int DEF_MAX_HOLD = 5;

  // Hold counter width: enough for MAX_HOLD, never
  // narrower than 3 bits so the port stays stable.
  function automatic int hold_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/req_grant_sched_rr_pick.sv
// Round-robin priority picker.
// First set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             valid_o
);

  logic [ID_W:0] idx;

  // Scan offsets high to low so the nearest wins last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ))
        idx = idx - (ID_W+1)'(N_REQ);
      if (req_i[idx[ID_W-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/req_grant_sched.sv
// Round-robin req/grant scheduler.
// Two-edge grant latency, bounded hold window.
module req_grant_sched
  import req_grant_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int ID_W     = $clog2(N_REQ),
  localparam int HW      = hold_w(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [HW-1:0]    hold_cnt
);

  if (MIN_HOLD < 1) begin : g_bad_min
    $fatal(1, "MIN_HOLD must be >= 1");
  end
  if (MAX_HOLD < MIN_HOLD) begin : g_bad_max
    $fatal(1, "MAX_HOLD must be >= MIN_HOLD");
  end

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   winner_q;
  logic [N_REQ-1:0]  grant_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              busy_q;
  logic [HW-1:0]     hold_q;

  logic [ID_W-1:0]   pick_id;
  logic              pick_vld;
  logic [ID_W-1:0]   ptr_d;
  logic              rel_d;
  logic [N_REQ-1:0]  onehot_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_id),
    .valid_o  (pick_vld)
  );

  // Next pointer, one-hot grant and release decision.
  always_comb begin
    ptr_d = (winner_q == ID_W'(N_REQ - 1))
          ? '0 : winner_q + 1'b1;
    onehot_d = {{(N_REQ-1){1'b0}}, 1'b1}
             << winner_q;
    rel_d = (hold_q == HW'(MAX_HOLD))
         || ((hold_q >= HW'(MIN_HOLD))
             && !req[winner_q]);
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            winner_q <= pick_id;
            state_q  <= PEND;
          end
        end
        PEND: begin
          grant_q    <= onehot_d;
          grant_id_q <= winner_q;
          busy_q     <= 1'b1;
          hold_q     <= HW'(1);
          ptr_q      <= ptr_d;
          state_q    <= GRANT;
        end
        GRANT: begin
          if (rel_d) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_req_grant_sched.sv
// Directed and random bench for req_grant_sched.
// Inputs driven and outputs observed on negedge.
module tb_req_grant_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic [2:0] hold_cnt;

  int checks = 0;
  int failures = 0;

  req_grant_sched #(
    .N_REQ    (4),
    .MIN_HOLD (3),
    .MAX_HOLD (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  // After j negedges from setting req, outputs
  // show the value sampled at edge E_j.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== 4'b0 || grant_id !== 2'd0
        || busy !== 1'b0 || hold_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset grant=%b id=%0d busy=%b hold=%0d want 0 0 0 0",
               grant, grant_id, busy, hold_cnt);
    end
    req = 4'b0000;
    do_reset();
  endtask

  task automatic test_single();
    logic [3:0] eg;
    logic [2:0] eh;
    do_reset();
    req = 4'b0001;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      eg = ((j >= 2 && j <= 6) || j >= 9)
         ? 4'b0001 : 4'b0000;
      eh = (j >= 2 && j <= 6) ? 3'(j - 1)
         : (j >= 9) ? 3'(j - 8) : 3'd0;
      checks++;
      if (grant !== eg || hold_cnt !== eh
          || busy !== (|eg)) begin
        failures++;
        $display("FAIL single E%0d grant=%b hold=%0d busy=%b want grant=%b hold=%0d",
                 j, grant, hold_cnt, busy, eg, eh);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_early_drop();
    logic [3:0] eg;
    do_reset();
    req = 4'b0100;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      eg = (j >= 2 && j <= 4) ? 4'b0100 : 4'b0;
      checks++;
      if (grant !== eg || busy !== (|eg)) begin
        failures++;
        $display("FAIL early_drop E%0d grant=%b busy=%b want grant=%b",
                 j, grant, busy, eg);
      end
      if (j == 4) req = 4'b0000;
    end
  endtask

  task automatic test_pulse();
    logic [3:0] eg;
    logic [2:0] eh;
    do_reset();
    req = 4'b0010;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) req = 4'b0000;
      eg = (j >= 2 && j <= 4) ? 4'b0010 : 4'b0;
      eh = (j >= 2 && j <= 4) ? 3'(j - 1) : 3'd0;
      checks++;
      if (grant !== eg || hold_cnt !== eh) begin
        failures++;
        $display("FAIL pulse E%0d grant=%b hold=%0d want grant=%b hold=%0d",
                 j, grant, hold_cnt, eg, eh);
      end
    end
  endtask

  task automatic test_round_robin();
    int ph;
    int k;
    logic [3:0] eg;
    logic [1:0] eid;
    do_reset();
    req = 4'b1111;
    for (int j = 1; j <= 37; j++) begin
      @(negedge clk);
      eg  = 4'b0;
      eid = 2'd0;
      ph  = 0;
      if (j >= 2) begin
        ph  = (j - 2) % 7;
        k   = (j - 2) / 7;
        eid = 2'(k % 4);
        if (ph < 5) eg = 4'b0001 << eid;
      end
      checks++;
      if (grant !== eg || busy !== (|eg)
          || ((|eg) && (grant_id !== eid
              || hold_cnt !== 3'(ph + 1)))) begin
        failures++;
        $display("FAIL round_robin E%0d grant=%b id=%0d hold=%0d want grant=%b id=%0d hold=%0d",
                 j, grant, grant_id, hold_cnt,
                 eg, eid, ph + 1);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [3:0] eg;
    do_reset();
    req = 4'b1000;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 1) req = 4'b0000;
      eg = (j >= 2 && j <= 4) ? 4'b1000
         : (j == 7) ? 4'b0010 : 4'b0;
      checks++;
      if (grant !== eg
          || (j == 7 && grant_id !== 2'd1)) begin
        failures++;
        $display("FAIL wrap E%0d grant=%b id=%0d want grant=%b",
                 j, grant, grant_id, eg);
      end
      if (j == 5) req = 4'b1010;
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] eg;
    logic [2:0] eh;
    do_reset();
    req = 4'b0011;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      eg = (j == 2 || j == 3 || j == 6)
         ? 4'b0001 : 4'b0;
      eh = (j == 2 || j == 6) ? 3'd1
         : (j == 3) ? 3'd2 : 3'd0;
      checks++;
      if (grant !== eg || hold_cnt !== eh
          || busy !== (|eg)
          || ((|eg) && grant_id !== 2'd0)) begin
        failures++;
        $display("FAIL reset_mid E%0d grant=%b id=%0d hold=%0d busy=%b want grant=%b hold=%0d",
                 j, grant, grant_id, hold_cnt, busy,
                 eg, eh);
      end
      if (j == 3) rst_n = 1'b0;
      if (j == 4) rst_n = 1'b1;
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    int run;
    int gap;
    do_reset();
    run = 0;
    gap = 2;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0)
        req = 4'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if ((grant & (grant - 4'd1)) !== 4'b0
          || busy !== (|grant)
          || hold_cnt > 3'd5) begin
        failures++;
        $display("FAIL rand_inv cyc=%0d grant=%b busy=%b hold=%0d",
                 c, grant, busy, hold_cnt);
      end
      if (busy) begin
        if (run == 0) begin
          checks++;
          if (gap < 2) begin
            failures++;
            $display("FAIL rand_gap cyc=%0d gap=%0d want >=2",
                     c, gap);
          end
        end
        run++;
        checks++;
        if (hold_cnt !== 3'(run)
            || grant[grant_id] !== 1'b1) begin
          failures++;
          $display("FAIL rand_hold cyc=%0d hold=%0d id=%0d grant=%b want hold=%0d",
                   c, hold_cnt, grant_id, grant, run);
        end
        gap = 0;
      end else begin
        if (run != 0) begin
          checks++;
          if (run < 3 || run > 5) begin
            failures++;
            $display("FAIL rand_window cyc=%0d len=%0d want 3..5",
                     c, run);
          end
        end
        run = 0;
        gap++;
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single();
    test_early_drop();
    test_pulse();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
